atm_session_controller: RTL and testbench

- Parametrised, multi-account successor to the single-user ATM controller.
- Runs one card session at a time: PIN check with a retry limit and per-account lockout, opcode dispatch and balance update, a chained-operation loop, an inactivity timeout, and card ejection.
- Holds the balance and PIN registers for NUM_ACCOUNTS accounts.
- Sits between the card/keypad front end and the display/dispenser logic.

---
 rtl/atm_session_controller.sv | 203 ++++++++++++++++++++
 tb/tb_atm_session_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_controller.sv
// Multi-account ATM session controller: PIN check with per-account lockout,
// opcode dispatch against per-account balances, inactivity timeout and eject.
module atm_session_controller #(
  parameter int unsigned      NUM_ACCOUNTS   = 4,
  parameter int unsigned      BAL_W          = 32,
  parameter int unsigned      PIN_W          = 4,
  parameter logic [PIN_W-1:0] DEFAULT_PIN    = 4'b1010,
  parameter logic [BAL_W-1:0] INIT_BALANCE   = 1000,
  parameter int unsigned      MAX_PIN_TRIES  = 3,
  parameter logic [BAL_W-1:0] MAX_WITHDRAW   = 5000,
  parameter int unsigned      TIMEOUT_CYCLES = 64,
  localparam int unsigned     ACC_W          = $clog2(NUM_ACCOUNTS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Card_Inserted,
  input  logic [ACC_W-1:0] Account_Sel,
  input  logic [ACC_W-1:0] Dest_Sel,
  input  logic [PIN_W-1:0] User_Pass,
  input  logic             Pass_Valid,
  input  logic [3:0]       Opcode,
  input  logic             Op_Valid,
  input  logic [BAL_W-1:0] Amount,
  input  logic             Another_Operation,
  input  logic             Cancel,
  output logic             Session_Active,
  output logic             Op_Done,
  output logic             Op_Error,
  output logic [BAL_W-1:0] Balance_Out,
  output logic             Card_Retained,
  output logic             ATM_Usage_Finished
);

  typedef enum logic [2:0] {
    S_IDLE, S_PIN_WAIT, S_MENU, S_EXEC, S_RESULT, S_EJECT, S_WAIT_REMOVE
  } state_t;

  localparam logic [3:0] OP_BALANCE    = 4'd1;
  localparam logic [3:0] OP_WITHDRAW   = 4'd2;
  localparam logic [3:0] OP_DEPOSIT    = 4'd3;
  localparam logic [3:0] OP_TRANSFER   = 4'd5;
  localparam logic [3:0] OP_CHANGE_PIN = 4'd8;

  localparam int unsigned      TRY_W    = $clog2(MAX_PIN_TRIES + 1);
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_PIN_TRIES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [ACC_W-1:0]        src;
  logic [ACC_W-1:0]        dst;
  logic [3:0]              op;
  logic [BAL_W-1:0]        amt;
  logic [BAL_W-1:0]        bal [NUM_ACCOUNTS];
  logic [PIN_W-1:0]        pin [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock;
  logic [TRY_W-1:0]        tries;
  logic [TMO_W-1:0]        tmo;

  logic             sel_bad;
  logic             dst_ok;
  logic             debit_ok;
  logic             exec_ok;
  logic [BAL_W-1:0] src_bal;
  logic [BAL_W-1:0] dst_bal;
  logic [BAL_W-1:0] new_src;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W:0]   xfer_sum;

  // Overflow is detected on a BAL_W+1 sum so a rejected deposit never wraps.
  always_comb begin
    sel_bad  = (32'(Account_Sel) >= NUM_ACCOUNTS) || lock[Account_Sel];
    src_bal  = bal[src];
    dst_bal  = bal[dst];
    dst_ok   = (32'(dst) < NUM_ACCOUNTS) && (dst != src);
    dep_sum  = {1'b0, src_bal} + {1'b0, amt};
    xfer_sum = {1'b0, dst_bal} + {1'b0, amt};
    debit_ok = (amt != '0) && (amt <= MAX_WITHDRAW) && (amt <= src_bal);
    exec_ok  = 1'b0;
    new_src  = src_bal;
    case (op)
      OP_BALANCE, OP_CHANGE_PIN: exec_ok = 1'b1;
      OP_WITHDRAW: begin
        exec_ok = debit_ok;
        new_src = src_bal - amt;
      end
      OP_DEPOSIT: begin
        exec_ok = (amt != '0) && !dep_sum[BAL_W];
        new_src = dep_sum[BAL_W-1:0];
      end
      OP_TRANSFER: begin
        exec_ok = dst_ok && debit_ok && !xfer_sum[BAL_W];
        new_src = src_bal - amt;
      end
      default: exec_ok = 1'b0;
    endcase
    if (!exec_ok) new_src = src_bal;
  end

  assign Session_Active = (state == S_PIN_WAIT) || (state == S_MENU) ||
                          (state == S_EXEC) || (state == S_RESULT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state              <= S_IDLE;
      src                <= '0;
      dst                <= '0;
      op                 <= '0;
      amt                <= '0;
      lock               <= '0;
      tries              <= '0;
      tmo                <= '0;
      Op_Done            <= 1'b0;
      Op_Error           <= 1'b0;
      Balance_Out        <= '0;
      Card_Retained      <= 1'b0;
      ATM_Usage_Finished <= 1'b0;
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        bal[i] <= INIT_BALANCE;
        pin[i] <= DEFAULT_PIN;
      end
    end else begin
      Op_Done            <= 1'b0;
      Op_Error           <= 1'b0;
      Card_Retained      <= 1'b0;
      ATM_Usage_Finished <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Card_Inserted) begin
            src <= Account_Sel;
            if (sel_bad) begin
              state              <= S_EJECT;
              Op_Error           <= 1'b1;
              ATM_Usage_Finished <= 1'b1;
            end else begin
              state <= S_PIN_WAIT;
            end
          end
        end

        // Interactive states share the removal > cancel > timeout > strobe order.
        S_PIN_WAIT, S_MENU, S_RESULT: begin
          if (!Card_Inserted) begin
            state <= S_IDLE;
            tries <= '0;
            tmo   <= '0;
          end else if (Cancel || (tmo == TMO_LAST)) begin
            state              <= S_EJECT;
            ATM_Usage_Finished <= 1'b1;
            tries              <= '0;
            tmo                <= '0;
          end else begin
            tmo <= (Pass_Valid || Op_Valid || Another_Operation) ? '0 : tmo + 1'b1;
            if (state == S_PIN_WAIT && Pass_Valid) begin
              if (User_Pass == pin[src]) begin
                tries <= '0;
                state <= S_MENU;
              end else if (tries == TRY_LAST) begin
                lock[src]          <= 1'b1;
                Card_Retained      <= 1'b1;
                Op_Error           <= 1'b1;
                ATM_Usage_Finished <= 1'b1;
                tries              <= '0;
                state              <= S_EJECT;
              end else begin
                tries    <= tries + 1'b1;
                Op_Error <= 1'b1;
              end
            end else if (state == S_MENU && Op_Valid) begin
              op    <= Opcode;
              amt   <= Amount;
              dst   <= Dest_Sel;
              state <= S_EXEC;
            end else if (state == S_RESULT && Another_Operation) begin
              state <= S_MENU;
            end
          end
        end

        S_EXEC: begin
          if (exec_ok) begin
            Op_Done  <= 1'b1;
            bal[src] <= new_src;
            if (op == OP_TRANSFER) bal[dst] <= xfer_sum[BAL_W-1:0];
            if (op == OP_CHANGE_PIN) pin[src] <= amt[PIN_W-1:0];
          end else begin
            Op_Error <= 1'b1;
          end
          Balance_Out <= new_src;
          tmo         <= '0;
          state       <= Card_Inserted ? S_RESULT : S_IDLE;
        end

        S_EJECT: state <= Card_Inserted ? S_WAIT_REMOVE : S_IDLE;

        S_WAIT_REMOVE: if (!Card_Inserted) state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_controller.sv
// Randomised self-checking bench for atm_session_controller against an
// account-level reference model (balances, PINs and locks as plain arrays).
module tb_atm_session_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Card_Inserted = 1'b0;
  logic [1:0]  Account_Sel = '0;
  logic [1:0]  Dest_Sel = '0;
  logic [3:0]  User_Pass = '0;
  logic        Pass_Valid = 1'b0;
  logic [3:0]  Opcode = '0;
  logic        Op_Valid = 1'b0;
  logic [31:0] Amount = '0;
  logic        Another_Operation = 1'b0;
  logic        Cancel = 1'b0;
  logic        Session_Active, Op_Done, Op_Error, Card_Retained, ATM_Usage_Finished;
  logic [31:0] Balance_Out;

  atm_session_controller #(
    .NUM_ACCOUNTS(4), .BAL_W(32), .PIN_W(4), .DEFAULT_PIN(4'b1010),
    .INIT_BALANCE(1000), .MAX_PIN_TRIES(3), .MAX_WITHDRAW(5000), .TIMEOUT_CYCLES(64)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Card_Inserted(Card_Inserted),
    .Account_Sel(Account_Sel), .Dest_Sel(Dest_Sel), .User_Pass(User_Pass),
    .Pass_Valid(Pass_Valid), .Opcode(Opcode), .Op_Valid(Op_Valid), .Amount(Amount),
    .Another_Operation(Another_Operation), .Cancel(Cancel),
    .Session_Active(Session_Active), .Op_Done(Op_Done), .Op_Error(Op_Error),
    .Balance_Out(Balance_Out), .Card_Retained(Card_Retained),
    .ATM_Usage_Finished(ATM_Usage_Finished)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mbal [4];
  logic [3:0]  mpin [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mbal[i] = 32'd1000;
      mpin[i] = 4'b1010;
    end
  endtask

  // Account-level rules: returns whether the operation succeeds and the source balance after it.
  function automatic bit model_op(input int s, input logic [3:0] op, input logic [31:0] a,
                                  input int d, output logic [31:0] bal_after);
    bit ok;
    longint unsigned limit = 64'h1_0000_0000;
    bit debit = (a != 0) && (a <= 5000) && (a <= mbal[s]);
    case (op)
      4'd1: ok = 1;
      4'd2: begin ok = debit; if (ok) mbal[s] = mbal[s] - a; end
      4'd3: begin
        ok = (a != 0) && (64'(mbal[s]) + 64'(a) < limit);
        if (ok) mbal[s] = mbal[s] + a;
      end
      4'd5: begin
        ok = (d != s) && (d < 4) && debit && (64'(mbal[d]) + 64'(a) < limit);
        if (ok) begin mbal[s] = mbal[s] - a; mbal[d] = mbal[d] + a; end
      end
      4'd8: begin ok = 1; mpin[s] = a[3:0]; end
      default: ok = 0;
    endcase
    bal_after = mbal[s];
    return ok;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1; Card_Inserted = 0; Pass_Valid = 0; Op_Valid = 0; Cancel = 0; Another_Operation = 0;
    tick(); tick();
    Reset = 0;
    model_reset();
    tick();
  endtask

  task automatic insert(input int acc);
    Card_Inserted = 1; Account_Sel = 2'(acc);
    tick();
  endtask

  task automatic pulse_pass(input logic [3:0] p);
    User_Pass = p; Pass_Valid = 1;
    tick();
    Pass_Valid = 0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input int d,
                       output logic early, output logic done, output logic err,
                       output logic [31:0] bal);
    Opcode = op; Amount = a; Dest_Sel = 2'(d); Op_Valid = 1;
    tick();
    Op_Valid = 0;
    early = Op_Done | Op_Error;
    tick();
    done = Op_Done; err = Op_Error; bal = Balance_Out;
  endtask

  task automatic again();
    Another_Operation = 1; tick(); Another_Operation = 0;
  endtask

  task automatic end_session();
    Cancel = 1; tick(); Cancel = 0; tick();
    Card_Inserted = 0; tick();
  endtask

  task automatic test_reset();
    Reset = 1; #3;
    n_tests++; if ({Session_Active, Op_Done, Op_Error, Card_Retained, ATM_Usage_Finished} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000",
        {Session_Active, Op_Done, Op_Error, Card_Retained, ATM_Usage_Finished}); end
    n_tests++; if (Balance_Out !== 32'd0) begin n_fail++; $display("FAIL reset_bal: got %0d want 0", Balance_Out); end
    do_reset();
  endtask

  task automatic test_withdraw();
    logic e, d, r; logic [31:0] b, xb; bit ok;
    insert(0);
    n_tests++; if (Session_Active !== 1'b1) begin n_fail++; $display("FAIL wd_active: got %b want 1", Session_Active); end
    pulse_pass(4'b1010);
    n_tests++; if (Op_Error !== 1'b0) begin n_fail++; $display("FAIL wd_pin: got err %b want 0", Op_Error); end
    ok = model_op(0, 4'd2, 32'd64, 0, xb);
    do_op(4'd2, 32'd64, 0, e, d, r, b);
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL wd_latency: early pulse %b want 0", e); end
    n_tests++; if (d !== ok || r !== !ok) begin n_fail++; $display("FAIL wd_done: got done=%b err=%b want done=%b", d, r, ok); end
    n_tests++; if (b !== 32'd936 || b !== xb) begin n_fail++; $display("FAIL wd_bal: got %0d want 936", b); end
    tick();
    n_tests++; if (Op_Done !== 1'b0) begin n_fail++; $display("FAIL wd_pulse_width: got %b want 0", Op_Done); end
    Cancel = 1; tick(); Cancel = 0;
    n_tests++; if (ATM_Usage_Finished !== 1'b1) begin n_fail++; $display("FAIL wd_eject: got %b want 1", ATM_Usage_Finished); end
    tick();
    n_tests++; if (ATM_Usage_Finished !== 1'b0) begin n_fail++; $display("FAIL wd_eject_pulse: got %b want 0", ATM_Usage_Finished); end
    Card_Inserted = 0; tick();
  endtask

  task automatic test_lockout();
    logic [3:0] wrong [3];
    wrong[0] = 4'b0001; wrong[1] = 4'b0010; wrong[2] = 4'b0011;
    insert(1);
    for (int i = 0; i < 3; i++) begin
      pulse_pass(wrong[i]);
      n_tests++; if (Op_Error !== 1'b1) begin n_fail++; $display("FAIL lock_err%0d: got %b want 1", i, Op_Error); end
      n_tests++; if (Card_Retained !== (i == 2)) begin n_fail++; $display("FAIL lock_retain%0d: got %b want %b", i, Card_Retained, i == 2); end
      n_tests++; if (ATM_Usage_Finished !== (i == 2)) begin n_fail++; $display("FAIL lock_eject%0d: got %b want %b", i, ATM_Usage_Finished, i == 2); end
    end
    tick(); Card_Inserted = 0; tick();
    insert(1);
    n_tests++; if ({Op_Error, ATM_Usage_Finished, Session_Active} !== 3'b110) begin
      n_fail++; $display("FAIL lock_reinsert: got err,fin,act=%b want 110", {Op_Error, ATM_Usage_Finished, Session_Active}); end
    tick(); Card_Inserted = 0; tick();
  endtask

  task automatic test_transfer();
    logic e, d, r; logic [31:0] b, xb; bit ok;
    logic [31:0] amts [3]; int dsts [3];
    amts[0] = 32'd300; amts[1] = 32'd800; amts[2] = 32'd10;
    dsts[0] = 2; dsts[1] = 2; dsts[2] = 0;
    do_reset();
    insert(0); pulse_pass(4'b1010);
    for (int i = 0; i < 3; i++) begin
      ok = model_op(0, 4'd5, amts[i], dsts[i], xb);
      do_op(4'd5, amts[i], dsts[i], e, d, r, b);
      n_tests++; if (d !== ok || r !== !ok) begin n_fail++; $display("FAIL xfer%0d_status: got done=%b err=%b want done=%b", i, d, r, ok); end
      n_tests++; if (b !== xb) begin n_fail++; $display("FAIL xfer%0d_bal: got %0d want %0d", i, b, xb); end
      again();
    end
    end_session();
    insert(2); pulse_pass(4'b1010);
    ok = model_op(2, 4'd1, 0, 0, xb);
    do_op(4'd1, 0, 0, e, d, r, b);
    n_tests++; if (b !== 32'd1300 || b !== xb) begin n_fail++; $display("FAIL xfer_dst_bal: got %0d want 1300", b); end
    end_session();
  endtask

  task automatic test_deposit();
    logic e, d, r; logic [31:0] b, xb; bit ok;
    logic [3:0] ops [3]; logic [31:0] amts [3]; logic [31:0] want [3];
    ops[0] = 4'd3; amts[0] = 32'hFFFF_FC18; want[0] = 32'd1000;
    ops[1] = 4'd3; amts[1] = 32'd5;         want[1] = 32'd1005;
    ops[2] = 4'd1; amts[2] = 32'd0;         want[2] = 32'd1005;
    insert(3); pulse_pass(4'b1010);
    for (int i = 0; i < 3; i++) begin
      ok = model_op(3, ops[i], amts[i], 0, xb);
      do_op(ops[i], amts[i], 0, e, d, r, b);
      n_tests++; if (d !== ok || r !== !ok) begin n_fail++; $display("FAIL dep%0d_status: got done=%b err=%b want done=%b", i, d, r, ok); end
      n_tests++; if (b !== want[i]) begin n_fail++; $display("FAIL dep%0d_bal: got %0d want %0d", i, b, want[i]); end
      again();
    end
    end_session();
  endtask

  task automatic test_change_pin();
    logic e, d, r; logic [31:0] b, xb; bit ok;
    insert(2); pulse_pass(mpin[2]);
    ok = model_op(2, 4'd8, 32'h0000_0006, 0, xb);
    do_op(4'd8, 32'h0000_0006, 0, e, d, r, b);
    n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL pin_change: got done %b want 1", d); end
    end_session();
    insert(2); pulse_pass(4'b1010);
    n_tests++; if (Op_Error !== 1'b1) begin n_fail++; $display("FAIL pin_old: got err %b want 1", Op_Error); end
    pulse_pass(4'b0110);
    n_tests++; if (Op_Error !== 1'b0) begin n_fail++; $display("FAIL pin_new: got err %b want 0", Op_Error); end
    ok = model_op(2, 4'd1, 0, 0, xb);
    do_op(4'd1, 0, 0, e, d, r, b);
    n_tests++; if (d !== 1'b1 || b !== xb) begin n_fail++; $display("FAIL pin_menu: got done=%b bal=%0d want 1/%0d", d, b, xb); end
    end_session();
  endtask

  task automatic test_random();
    logic e, d, r; logic [31:0] b, xb, a; logic [3:0] op; bit ok; int acc, dst;
    logic [3:0] legal [5];
    legal[0] = 4'd1; legal[1] = 4'd2; legal[2] = 4'd3; legal[3] = 4'd5; legal[4] = 4'd8;
    for (int s = 0; s < 6; s++) begin
      acc = $urandom_range(0, 3);
      insert(acc); pulse_pass(mpin[acc]);
      n_tests++; if (Session_Active !== 1'b1 || Op_Error !== 1'b0) begin
        n_fail++; $display("FAIL rnd_login%0d: got act=%b err=%b want 1/0", s, Session_Active, Op_Error); end
      for (int k = 0; k < 8; k++) begin
        op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 4)];
        case ($urandom_range(0, 4))
          0: a = 32'd0;
          1: a = $urandom_range(1, 1500);
          2: a = $urandom_range(4000, 6000);
          3: a = 32'hFFFF_FFFF - $urandom_range(0, 3000);
          default: a = $urandom;
        endcase
        dst = $urandom_range(0, 3);
        ok = model_op(acc, op, a, dst, xb);
        do_op(op, a, dst, e, d, r, b);
        n_tests++; if (e !== 1'b0 || d !== ok || r !== !ok || b !== xb) begin
          n_fail++; $display("FAIL rnd_op s%0d k%0d op%0d amt%0d: got early=%b done=%b err=%b bal=%0d want 0/%b/%b/%0d",
            s, k, op, a, e, d, r, b, ok, !ok, xb); end
        again();
      end
      end_session();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    insert(0); pulse_pass(mpin[0]);
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (ATM_Usage_Finished || Op_Error) begin n = i; break; end
    end
    n_tests++; if (n !== 64) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 64", n); end
    n_tests++; if (Op_Error !== 1'b0) begin n_fail++; $display("FAIL timeout_err: got %b want 0", Op_Error); end
    tick(); Card_Inserted = 0; tick();
  endtask

  task automatic test_pull_card();
    insert(3); pulse_pass(mpin[3]);
    Card_Inserted = 0; tick();
    n_tests++; if (Session_Active !== 1'b0 || ATM_Usage_Finished !== 1'b0) begin
      n_fail++; $display("FAIL pull_idle: got act=%b fin=%b want 0/0", Session_Active, ATM_Usage_Finished); end
    tick();
    n_tests++; if (ATM_Usage_Finished !== 1'b0) begin n_fail++; $display("FAIL pull_nofin: got %b want 0", ATM_Usage_Finished); end
    insert(3);
    n_tests++; if (Session_Active !== 1'b1) begin n_fail++; $display("FAIL pull_reinsert: got %b want 1", Session_Active); end
    Card_Inserted = 0; tick();
  endtask

  task automatic test_reset_mid_exec();
    logic e, d, r; logic [31:0] b;
    insert(0); pulse_pass(mpin[0]);
    Opcode = 4'd2; Amount = 32'd100; Op_Valid = 1; tick(); Op_Valid = 0;
    Reset = 1; #2;
    n_tests++; if (Session_Active !== 1'b0 || Balance_Out !== 32'd0) begin
      n_fail++; $display("FAIL rst_exec: got act=%b bal=%0d want 0/0", Session_Active, Balance_Out); end
    Card_Inserted = 0; tick(); Reset = 0; tick();
    model_reset();
    for (int a = 0; a < 4; a++) begin
      insert(a); pulse_pass(4'b1010);
      n_tests++; if (Session_Active !== 1'b1 || Op_Error !== 1'b0) begin
        n_fail++; $display("FAIL rst_login%0d: got act=%b err=%b want 1/0", a, Session_Active, Op_Error); end
      do_op(4'd1, 0, 0, e, d, r, b);
      n_tests++; if (b !== mbal[a]) begin n_fail++; $display("FAIL rst_bal%0d: got %0d want %0d", a, b, mbal[a]); end
      end_session();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_withdraw();
    test_lockout();
    test_transfer();
    test_deposit();
    test_change_pin();
    test_random();
    test_timeout();
    test_pull_card();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

endmodule
